// File: rtl/tetris_board_renderer_pkg.sv
// Shared constants, types and helpers for the Tetris board renderer:
// playfield geometry, colour indices, palette and cell addressing.
package tetris_board_renderer_pkg;

  localparam int BOARD_X0   = 240;
  localparam int BOARD_Y0   = 80;
  localparam int CELL_SHIFT = 4;
  localparam int COLS       = 10;
  localparam int ROWS       = 20;
  localparam int CELLS      = COLS * ROWS;
  localparam int BOARD_W    = COLS << CELL_SHIFT;
  localparam int BOARD_H    = ROWS << CELL_SHIFT;

  // Geometry in the 12-bit signed domain used by the address stage.
  localparam logic signed [11:0] X0_S  = 12'(BOARD_X0);
  localparam logic signed [11:0] Y0_S  = 12'(BOARD_Y0);
  localparam logic signed [11:0] DX_HI = 12'(BOARD_W);
  localparam logic signed [11:0] DY_HI = 12'(BOARD_H);
  localparam logic signed [11:0] RING  = 12'sd2;

  localparam logic [7:0] LAST_ADDR = 8'(CELLS - 1);

  // Colour indices shared with the game logic.
  localparam logic [2:0] CLR_EMPTY = 3'd0;
  localparam logic [2:0] CLR_I     = 3'd1;
  localparam logic [2:0] CLR_O     = 3'd2;
  localparam logic [2:0] CLR_T     = 3'd3;
  localparam logic [2:0] CLR_S     = 3'd4;
  localparam logic [2:0] CLR_Z     = 3'd5;
  localparam logic [2:0] CLR_J     = 3'd6;
  localparam logic [2:0] CLR_L     = 3'd7;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = 24'h000000;
  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_EMPTY = 24'h202020;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  // Fixed piece palette; the empty index is handled by the caller.
  function automatic rgb_t palette(input logic [2:0] idx);
    case (idx)
      CLR_I:   return 24'h00FFFF;
      CLR_O:   return 24'hFFFF00;
      CLR_T:   return 24'hA000F0;
      CLR_S:   return 24'h00F000;
      CLR_Z:   return 24'hF00000;
      CLR_J:   return 24'h0000F0;
      CLR_L:   return 24'hF0A000;
      default: return RGB_BLACK;
    endcase
  endfunction

  // row*10 + col as shift-add; row*8 + row*2 keeps it multiplier-free.
  function automatic logic [7:0] cell_addr(input logic [4:0] row, input logic [3:0] col);
    logic [7:0] r8;
    r8 = {3'b000, row};
    return (r8 << 3) + (r8 << 1) + {4'b0000, col};
  endfunction

endpackage

// File: rtl/tetris_board_renderer_board_ram.sv
// Simple dual-port board RAM: write port A, synchronous read port B.
// A read and write of the same address on one edge returns the old word.
module board_ram #(
  parameter int AW = 8,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // NOTE: the array has no reset; contents are initialised by the clear sweep,
  // and resetting a RAM would prevent it mapping onto a memory macro.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port A and registered read port B.
  // NOTE: both use <=, so a same-edge read of the written address sees the
  // pre-write value (read-old behaviour) instead of a simulation race.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tetris_board_renderer.sv
// Pixel stage after the VGA timing block: maps beam position to a playfield
// cell, reads its colour index, applies the palette and bevel, and outputs
// registered RGB with sync/blank delayed to the same 3-cycle latency.
// Also owns the clear sweep that zeroes the board after reset or on CLR.
module tetris_board_renderer
  import tetris_board_renderer_pkg::*;
(
  input  logic        CLK_25,
  input  logic        RST_N,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic        HS_IN,
  input  logic        VS_IN,
  input  logic        BLANK_IN_N,
  input  logic        WR_EN,
  input  logic [4:0]  WR_ROW,
  input  logic [3:0]  WR_COL,
  input  logic [2:0]  WR_COLOR,
  input  logic        CLR,
  output logic        BUSY,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);

  // ---------------- clear sweep FSM ----------------
  clr_state_t state, state_nxt;
  logic [7:0] clr_addr, clr_addr_nxt;
  logic       busy_int, clear_we;

  // State register; reset parks the FSM at the start of a sweep so the
  // board is cleared from the first cycle after release.
  always_ff @(posedge CLK_25) begin
    if (!RST_N) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Next state: CLR (re)starts at address 0, sweep ends after the last cell.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      ST_IDLE: begin
        if (CLR) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (CLR) begin
          clr_addr_nxt = '0;
        end else if (clr_addr == LAST_ADDR) begin
          state_nxt    = ST_IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 8'd1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        clr_addr_nxt = '0;
      end
    endcase
  end

  // FSM outputs: busy and the sweep's write strobe.
  always_comb begin
    busy_int = (state == ST_CLEAR);
    clear_we = (state == ST_CLEAR);
  end

  assign BUSY = busy_int;

  // ---------------- RAM write port ----------------
  logic       user_we, ram_we;
  logic [7:0] ram_wr_addr;
  logic [2:0] ram_wr_data;

  // Sweep owns the write port while busy; user writes need idle and in-range.
  always_comb begin
    user_we     = WR_EN && !busy_int && (WR_ROW < 5'(ROWS)) && (WR_COL < 4'(COLS));
    ram_we      = clear_we || user_we;
    ram_wr_addr = clear_we ? clr_addr  : cell_addr(WR_ROW, WR_COL);
    ram_wr_data = clear_we ? CLR_EMPTY : WR_COLOR;
  end

  // ---------------- S1: geometry ----------------
  logic signed [11:0] dx, dy;
  logic               in_board_c, border_c, bevel_c;
  logic [7:0]         addr_c;

  // Board-relative offsets, inside/border classification and cell address.
  always_comb begin
    dx         = $signed({1'b0, X}) - X0_S;
    dy         = $signed({1'b0, Y}) - Y0_S;
    in_board_c = (dx >= 12'sd0) && (dx < DX_HI) && (dy >= 12'sd0) && (dy < DY_HI);
    border_c   = !in_board_c &&
                 (dx >= -RING) && (dx < DX_HI + RING) &&
                 (dy >= -RING) && (dy < DY_HI + RING);
    bevel_c    = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);
    addr_c     = cell_addr(dy[CELL_SHIFT+4:CELL_SHIFT], dx[CELL_SHIFT+3:CELL_SHIFT]);
  end

  logic [7:0] s1_addr;
  logic       s1_in_board, s1_border, s1_bevel, s1_hs, s1_vs, s1_blank_n;

  // S1 register: cell address, flags and syncs.
  always_ff @(posedge CLK_25) begin
    if (!RST_N) begin
      s1_addr     <= '0;
      s1_in_board <= 1'b0;
      s1_border   <= 1'b0;
      s1_bevel    <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_blank_n  <= 1'b0;
    end else begin
      s1_addr     <= addr_c;
      s1_in_board <= in_board_c;
      s1_border   <= border_c;
      s1_bevel    <= bevel_c;
      s1_hs       <= HS_IN;
      s1_vs       <= VS_IN;
      s1_blank_n  <= BLANK_IN_N;
    end
  end

  // ---------------- S2: RAM read ----------------
  logic [2:0] s2_color;
  logic       s2_in_board, s2_border, s2_bevel, s2_hs, s2_vs, s2_blank_n;

  board_ram #(.AW(8), .DW(3)) u_board_ram (
    .clk     (CLK_25),
    .we      (ram_we),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (s1_addr),
    .rd_data (s2_color)
  );

  // S2 register: carry flags alongside the RAM read.
  always_ff @(posedge CLK_25) begin
    if (!RST_N) begin
      s2_in_board <= 1'b0;
      s2_border   <= 1'b0;
      s2_bevel    <= 1'b0;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
      s2_blank_n  <= 1'b0;
    end else begin
      s2_in_board <= s1_in_board;
      s2_border   <= s1_border;
      s2_bevel    <= s1_bevel;
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
      s2_blank_n  <= s1_blank_n;
    end
  end

  // ---------------- S3: colour ----------------
  rgb_t pal_c, pix_c, s3_rgb;

  // Colour priority: blank, border, outside, empty cell, palette with bevel.
  always_comb begin
    pal_c = palette(s2_color);
    if (s2_bevel) begin
      pal_c.r = pal_c.r >> 1;
      pal_c.g = pal_c.g >> 1;
      pal_c.b = pal_c.b >> 1;
    end
    if (!s2_blank_n)                pix_c = RGB_BLACK;
    else if (s2_border)             pix_c = RGB_WHITE;
    else if (!s2_in_board)          pix_c = RGB_BLACK;
    else if (s2_color == CLR_EMPTY) pix_c = RGB_EMPTY;
    else                            pix_c = pal_c;
  end

  // S3 register: pixel colour and delayed syncs.
  always_ff @(posedge CLK_25) begin
    if (!RST_N) begin
      s3_rgb      <= RGB_BLACK;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      s3_rgb      <= pix_c;
      VGA_HS      <= s2_hs;
      VGA_VS      <= s2_vs;
      VGA_BLANK_N <= s2_blank_n;
    end
  end

  assign VGA_R = s3_rgb.r;
  assign VGA_G = s3_rgb.g;
  assign VGA_B = s3_rgb.b;

endmodule
